// File: rtl/fnd_scan_reader.sv
// Loopback monitor for a multiplexed active-low 7-segment display drive.
// Waits for each scanned digit to settle, then decodes the segments back to hex per digit.
module fnd_scan_reader #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     an_n,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   hex_out,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  pat_err,
    output logic                  err_sticky,
    output logic                  frame_done
);

    localparam int         SW     = DIGITS + 7;
    localparam logic [7:0] STABLE = 8'(STABLE_CYC);

    logic [SW-1:0]     smp;
    logic [SW-1:0]     prv;
    logic [7:0]        cnt;
    logic [7:0]        cnt_nxt;
    logic              capture;
    logic [DIGITS-1:0] an;
    logic              one_hot;
    logic [DIGITS-1:0] sel;
    logic [DIGITS-1:0] seen;
    logic [6:0]        pat;
    logic [3:0]        nib;
    logic              legal;
    logic              blank;

    // Stability counter and single-shot capture strobe.
    always_comb begin
        cnt_nxt = cnt;
        if (smp != prv) begin
            cnt_nxt = 8'd1;
        end else if (cnt < STABLE) begin
            cnt_nxt = cnt + 8'd1;
        end
        // NOTE: capture is an edge of the count reaching STABLE, not a level, so a
        // held value fires once; a change counts as an edge too when STABLE is 1.
        capture = (cnt_nxt == STABLE) && ((smp != prv) || (cnt != STABLE));
    end

    // Digit select: only a single low enable names a digit unambiguously.
    always_comb begin
        an      = ~smp[SW-1:7];
        one_hot = (an != '0) && ((an & (an - DIGITS'(1))) == '0);
        sel     = (capture && one_hot && !clr) ? an : '0;
    end

    always_comb begin
        pat   = ~smp[6:0];
        blank = (pat == 7'h00);
        legal = 1'b1;
        nib   = 4'h0;
        case (pat)
            7'h3f: nib = 4'h0;
            7'h06: nib = 4'h1;
            7'h5b: nib = 4'h2;
            7'h4f: nib = 4'h3;
            7'h66: nib = 4'h4;
            7'h6d: nib = 4'h5;
            7'h7d: nib = 4'h6;
            7'h27: nib = 4'h7;
            7'h7f: nib = 4'h8;
            7'h6f: nib = 4'h9;
            7'h5f: nib = 4'ha;
            7'h7c: nib = 4'hb;
            7'h58: nib = 4'hc;
            7'h5e: nib = 4'hd;
            7'h7b: nib = 4'he;
            7'h71: nib = 4'hf;
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the sample pipe resets to "blank, no digit" rather than zero so
            // the first real input is seen as a change and restarts the count.
            smp         <= '1;
            prv         <= '1;
            cnt         <= 8'd0;
            hex_out     <= '0;
            digit_valid <= '0;
            pat_err     <= 1'b0;
            err_sticky  <= 1'b0;
            frame_done  <= 1'b0;
            seen        <= '0;
        end else begin
            smp        <= {an_n, seg_n};
            prv        <= smp;
            cnt        <= cnt_nxt;
            pat_err    <= 1'b0;
            frame_done <= 1'b0;
            if (clr) begin
                hex_out     <= '0;
                digit_valid <= '0;
                err_sticky  <= 1'b0;
                seen        <= '0;
            end else begin
                // A full frame clears tracking; a capture on the same edge starts the next one.
                frame_done <= &seen;
                seen       <= ((&seen) ? '0 : seen) | sel;
                for (int i = 0; i < DIGITS; i++) begin
                    if (sel[i]) begin
                        digit_valid[i] <= legal;
                        if (legal) begin
                            hex_out[4*i +: 4] <= nib;
                        end
                    end
                end
                if ((sel != '0) && !legal && !blank) begin
                    pat_err    <= 1'b1;
                    err_sticky <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_reader.sv
// Directed bench for fnd_scan_reader: stimulus pushes timed expected output events,
// a monitor pops one whenever the outputs change or a pulse is seen.
module tb_fnd_scan_reader;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        clr   = 1'b0;
    logic [6:0]  seg_n = 7'h7f;
    logic [3:0]  an_n  = 4'hf;
    logic [15:0] hex_out;
    logic [3:0]  digit_valid;
    logic        pat_err;
    logic        err_sticky;
    logic        frame_done;

    fnd_scan_reader #(.DIGITS(4), .STABLE_CYC(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .clr         (clr),
        .hex_out     (hex_out),
        .digit_valid (digit_valid),
        .pat_err     (pat_err),
        .err_sticky  (err_sticky),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          cyc;
        logic [15:0] hex;
        logic [3:0]  dv;
        logic        pe;
        logic        es;
        logic        fd;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          t0     = 0;
    logic [20:0] last   = '0;
    logic [20:0] cur;
    exp_t        e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_at(input int c, input logic [15:0] h, input logic [3:0] d,
                             input logic pe, input logic es, input logic fd);
        exp_t x;
        x.cyc = c; x.hex = h; x.dv = d; x.pe = pe; x.es = es; x.fd = fd;
        sb.push_back(x);
    endtask

    task automatic set_in(input logic [3:0] a, input logic [6:0] s);
        @(negedge clk);
        an_n  = a;
        seg_n = s;
        t0    = cyc;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Monitor: an output event is any pulse or any change of the held outputs.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cur = {hex_out, digit_valid, err_sticky};
            if (pat_err || frame_done || (cur != last)) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_event: hex=%h dv=%b pe=%b es=%b fd=%b at cycle %0d, none expected",
                             hex_out, digit_valid, pat_err, err_sticky, frame_done, cyc);
                end else begin
                    e = sb.pop_front();
                    check("event_cycle", 32'(cyc), 32'(e.cyc));
                    check("event_outputs", {9'd0, hex_out, digit_valid, pat_err, err_sticky, frame_done},
                          {9'd0, e.hex, e.dv, e.pe, e.es, e.fd});
                end
            end
            last = cur;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_hex", 32'(hex_out), 32'h0);
        check("reset_flags", {27'd0, digit_valid, err_sticky}, 32'h0);
        check("reset_pulses", {30'd0, pat_err, frame_done}, 32'h0);
        wait_n(8);

        // Full scan of digits 0..3 showing 0,1,2,3.
        set_in(4'b1110, ~7'h3f); expect_at(t0 + 5, 16'h0000, 4'b0001, 1'b0, 1'b0, 1'b0); wait_n(6);
        set_in(4'b1101, ~7'h06); expect_at(t0 + 5, 16'h0010, 4'b0011, 1'b0, 1'b0, 1'b0); wait_n(6);
        set_in(4'b1011, ~7'h5b); expect_at(t0 + 5, 16'h0210, 4'b0111, 1'b0, 1'b0, 1'b0); wait_n(6);
        set_in(4'b0111, ~7'h4f); expect_at(t0 + 5, 16'h3210, 4'b1111, 1'b0, 1'b0, 1'b0);
                                 expect_at(t0 + 6, 16'h3210, 4'b1111, 1'b0, 1'b0, 1'b1); wait_n(6);

        // Too-short hold: no capture.
        set_in(4'b1101, ~7'h7c); wait_n(3);

        // Illegal pattern on digit 2.
        set_in(4'b1011, ~7'h01); expect_at(t0 + 5, 16'h3210, 4'b1011, 1'b1, 1'b1, 1'b0); wait_n(4);

        // Digit 0 shows 'e', then goes blank.
        set_in(4'b1110, ~7'h7b); expect_at(t0 + 5, 16'h321e, 4'b1011, 1'b0, 1'b1, 1'b0); wait_n(6);
        set_in(4'b1110, 7'h7f);  expect_at(t0 + 5, 16'h321e, 4'b1010, 1'b0, 1'b1, 1'b0); wait_n(6);

        // Two digits enabled at once: ignored. Then clear.
        set_in(4'b0011, ~7'h3f); wait_n(10);
        @(negedge clk);
        clr = 1'b1;
        expect_at(cyc + 1, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        clr = 1'b0;
        wait_n(6);

        // Load digit 1 with '5' so the reset below is visible.
        set_in(4'b1101, ~7'h6d); expect_at(t0 + 5, 16'h0050, 4'b0010, 1'b0, 1'b0, 1'b0); wait_n(6);

        // Reset in the middle of holding '8' on digit 3.
        set_in(4'b0111, ~7'h7f); wait_n(2);
        @(negedge clk);
        rst = 1'b1;
        expect_at(cyc + 1, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        t0  = cyc;
        expect_at(t0 + 5, 16'h8000, 4'b1000, 1'b0, 1'b0, 1'b0);
        wait_n(6);

        set_in(4'hf, 7'h7f);
        wait_n(10);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fnd_scan_reader.md
Name: fnd_scan_reader

Overview:
- Receive-side monitor for the multiplexed 7-segment (FND) display drive.
- Samples the active-low segment and digit-enable lines produced by the display path, waits for each scanned digit to hold stable, and decodes each segment pattern back to a 4-bit hex value per digit.
- Flags illegal patterns and marks complete scan frames.
- Used on-chip for loopback checking of the adder/FND display path.

Parameters:
- DIGITS, 4, number of scanned digits (legal 1..8).
- STABLE_CYC, 4, consecutive identical samples required before a digit is captured (legal 1..255).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- seg_n  input  7  active-low segments; bit0=a, bit1=b … bit6=g.
- an_n  input  DIGITS  active-low digit enables; bit i low selects digit i.
- clr  input  1  synchronous clear of captured state, error flag and frame tracking.
- hex_out  output  4*DIGITS  decoded nibbles; digit i occupies bits [4i+3:4i].
- digit_valid  output  DIGITS  bit i set when digit i last captured a legal hex pattern.
- pat_err  output  1  one-cycle pulse on capture of an illegal pattern.
- err_sticky  output  1  set by any pat_err; cleared only by clr or rst.
- frame_done  output  1  one-cycle pulse when every digit has been captured since the last pulse or clear.

Behaviour:
- Decode table (active-high pattern g..a; pins carry the inverse):
  - 0=3f, 1=06, 2=5b, 3=4f, 4=66, 5=6d, 6=7d, 7=27
  - 8=7f, 9=6f, a=5f, b=7c, c=58, d=5e, e=7b, f=71
- Legality: only these 16 patterns are legal. Blank = all segments off (seg_n=7f). Any other pattern is illegal.
- Input stage:
  - {an_n, seg_n} registered every cycle into smp.
  - Previous smp held in prv.
- Stability counter cnt (8 bits, saturating at STABLE_CYC):
  - Reloads to 1 when smp != prv.
  - Increments while smp == prv and cnt < STABLE_CYC.
- Capture event:
  - Fires in exactly the one cycle where cnt becomes STABLE_CYC. No re-capture while the value keeps holding.
  - Latency: inputs changed before edge 1 and held through edge STABLE_CYC → outputs update on edge STABLE_CYC+1.
- On capture, if an_n has exactly one low bit i:
  - Legal hex pattern: hex_out[i] = decoded nibble; digit_valid[i] = 1.
  - Blank: digit_valid[i] = 0; hex_out[i] unchanged; no error.
  - Illegal: digit_valid[i] = 0; hex_out[i] unchanged; pat_err = 1 for one cycle; err_sticky = 1.
  - In all three cases seen[i] = 1.
- On capture with an_n all high or more than one bit low: no update, no error (scan gap / ghosting).
- Frame tracking:
  - When seen becomes all-ones, frame_done pulses one cycle and seen clears on the same edge.
  - A capture landing on that edge sets its seen bit after the clear.
- clr (synchronous):
  - Zeroes hex_out, digit_valid, err_sticky and seen.
  - Suppresses a coincident capture and pat_err.
  - Does not reset cnt/smp/prv; a held value is not re-captured after clr.
- Reset (async):
  - hex_out=0, digit_valid=0, pat_err=0, err_sticky=0, frame_done=0, seen=0, cnt=0.
  - smp/prv = all ones (blank, no digit), so the first real input counts as a change.
  - Reset mid-hold discards the partial count.

Test Plan:
- Reset, then scan digits 0..3 with seg_n=~3f, ~06, ~5b, ~4f, each held 6 cycles (STABLE_CYC=4) → hex_out=16'h3210, digit_valid=4'hf, frame_done one pulse after digit 3 capture; each update lands exactly 5 edges after the input change.
- Hold digit 1 with seg_n=~7c for only 3 cycles, then change → no capture; hex_out and digit_valid unchanged.
- Digit 2 with illegal seg_n=~7'h00 ^ 7'h01 (pattern 01) held 4 cycles → pat_err pulses once, err_sticky=1, digit_valid[2]=0, hex_out[11:8] retained.
- Digit 0 blank (seg_n=7f) after holding 'e' (~7b) → digit_valid[0]=0, hex_out[3:0] stays 4'he, no pat_err.
- an_n=4'b0011 (two digits low) held 10 cycles → no update, no pat_err, seen unchanged; then clr pulse → all outputs 0, err_sticky=0.
- Assert rst for 1 cycle midway through a 4-cycle hold of '8' (~7f) on digit 3 → outputs 0 immediately; input held 4 full cycles after release → hex_out[15:12]=8, digit_valid[3]=1.
